// File: rtl/seq_mult_pkg.sv
// Shared state encodings and default sizes for the sequential multiplier
// and the register file it writes into.
package seq_mult_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_mult_dff_ar.sv
// Async-reset register, cleared to zero; used for every state and
// datapath flop in the multiplier.
module dff_ar #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/seq_mult.sv
// Shift-and-add unsigned multiplier: one multiplier bit per cycle,
// result written to the register file in a single-cycle DONE state.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [SEL_W-1:0] dstSel,
  output logic             busy,
  output logic             writeEn,
  output logic [SEL_W-1:0] writeRegSel,
  output logic [WIDTH-1:0] writeData,
  output logic             ovf,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         st_q;
  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_sum;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   dst_q, dst_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [SEL_W-1:0]   wsel_q, wsel_d;
  logic               err_q, err_d;

  assign state_q = state_e'(st_q);

  dff_ar #(.W(2))       u_st    (.clk(clk), .rst(rst), .d(state_d),  .q(st_q));
  dff_ar #(.W(2*WIDTH)) u_acc   (.clk(clk), .rst(rst), .d(acc_d),    .q(acc_q));
  dff_ar #(.W(2*WIDTH)) u_mcand (.clk(clk), .rst(rst), .d(mcand_d),  .q(mcand_q));
  dff_ar #(.W(WIDTH))   u_mplr  (.clk(clk), .rst(rst), .d(mplier_d), .q(mplier_q));
  dff_ar #(.W(CNT_W))   u_cnt   (.clk(clk), .rst(rst), .d(cnt_d),    .q(cnt_q));
  dff_ar #(.W(SEL_W))   u_dst   (.clk(clk), .rst(rst), .d(dst_d),    .q(dst_q));
  dff_ar #(.W(WIDTH))   u_wdata (.clk(clk), .rst(rst), .d(wdata_d),  .q(wdata_q));
  dff_ar #(.W(SEL_W))   u_wsel  (.clk(clk), .rst(rst), .d(wsel_d),   .q(wsel_q));
  dff_ar #(.W(1))       u_err   (.clk(clk), .rst(rst), .d(err_d),    .q(err_q));

  assign acc_sum = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    dst_d    = dst_q;
    wdata_d  = wdata_q;
    wsel_d   = wsel_q;
    err_d    = start && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, opA};
          mplier_d = opB;
          dst_d    = dstSel;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Output data/select are captured once so they hold between results
        if (cnt_q == LAST) begin
          wdata_d = acc_sum[WIDTH-1:0];
          wsel_d  = dst_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign writeEn     = (state_q == DONE);
  assign writeData   = wdata_q;
  assign writeRegSel = wsel_q;
  assign ovf         = writeEn && (|acc_q[2*WIDTH-1:WIDTH]);
  assign err         = err_q;

endmodule
